// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 link scheduler.
package rs422_pkg;

    localparam int unsigned CMD_W = 32;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_CHK  = 2'd1;
    localparam logic [1:0] MODE_HDLC = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StChkRun,
        StHLoad,
        StHRun,
        StGap
    } sched_state_e;

endpackage

// File: rtl/rs422_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module rs422_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/rs422_link_sched.sv
// Arbitrates the RS422 link between self-check runs and queued HDLC frames.
// Optional run timeout is enabled by defining RS422_SCHED_TIMEOUT_EN.
module rs422_link_sched
    import rs422_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned INTER_GAP   = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    input  logic [CMD_W-1:0]            cmd_word,
    output logic                        cmd_ready,
    input  logic                        chk_req,
    input  logic                        chk_done,
    input  logic                        hdlc_tx_done,
    input  logic                        hdlc_rx_done,
    input  logic                        err_clr,
    output logic                        chk_start,
    output logic                        hdlc_start,
    output logic [CMD_W-1:0]            hdlc_cmd,
    output logic                        eng_abort,
    output logic [1:0]                  mode,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 frame_cnt,
    output logic                        err_ovf,
    output logic                        err_tmo
);
    localparam logic [7:0] GAP_LAST = 8'(INTER_GAP - 1);

    sched_state_e     state_q, state_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_head;
    logic             rdy_en_q, chk_pend_q, tx_seen_q, rx_seen_q, hdlc_start_q, err_ovf_q;
    logic [CMD_W-1:0] hdlc_cmd_q;
    logic [15:0]      frame_cnt_q;
    logic [7:0]       gap_cnt_q;
    logic             tx_got, rx_got, frame_done, abort, tmo_hit;

    // Held low for the first cycle after reset so every output reads 0 while in reset.
    assign cmd_ready = rdy_en_q & ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;

    rs422_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (cmd_word),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tx_got = tx_seen_q | hdlc_tx_done;
    assign rx_got = rx_seen_q | hdlc_rx_done;

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        chk_start  = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (chk_pend_q) begin
                    chk_start = 1'b1;
                    state_d   = StChkRun;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StHLoad;
                end
            end
            StChkRun: begin
                if (chk_done) begin
                    state_d = StGap;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = StGap;
                end
            end
            StHLoad: state_d = StHRun;
            StHRun: begin
                if (tx_got && rx_got) begin
                    frame_done = 1'b1;
                    state_d    = StGap;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_LAST) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            rdy_en_q     <= 1'b0;
            chk_pend_q   <= 1'b0;
            tx_seen_q    <= 1'b0;
            rx_seen_q    <= 1'b0;
            hdlc_start_q <= 1'b0;
            hdlc_cmd_q   <= '0;
            frame_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            chk_pend_q   <= chk_req | (chk_pend_q & ~chk_start);
            hdlc_start_q <= (state_q == StHLoad);
            if (fifo_pop) hdlc_cmd_q <= fifo_head;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            gap_cnt_q    <= (state_q == StGap) ? gap_cnt_q + 8'd1 : 8'd0;
            // Done latches live only while a frame is in flight.
            tx_seen_q    <= (state_q == StHRun) && (state_d == StHRun) && tx_got;
            rx_seen_q    <= (state_q == StHRun) && (state_d == StHRun) && rx_got;
            err_ovf_q    <= err_clr ? 1'b0 : (err_ovf_q | (cmd_valid & fifo_full));
        end
    end

`ifdef RS422_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_tmo_q;
    logic          run_state;

    assign run_state = (state_q == StChkRun) || (state_q == StHRun);
    assign tmo_hit   = run_state && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= run_state ? tmo_cnt_q + 1'b1 : '0;
            err_tmo_q <= err_clr ? 1'b0 : (err_tmo_q | abort);
        end
    end

    assign err_tmo = err_tmo_q;
`else
    // Constant 0; the term keeps TIMEOUT_CYC referenced in the default build.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYC != 0);
    assign err_tmo = 1'b0;
`endif

    always_comb begin
        mode = MODE_IDLE;
        if (state_q == StChkRun) mode = MODE_CHK;
        else if (state_q == StHLoad || state_q == StHRun) mode = MODE_HDLC;
    end

    assign busy       = (state_q != StIdle);
    assign hdlc_start = hdlc_start_q;
    assign hdlc_cmd   = hdlc_cmd_q;
    assign eng_abort  = abort;
    assign frame_cnt  = frame_cnt_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_rs422_link_sched.sv
// Bench for rs422_link_sched: scenario tasks plus a scoreboard of expected HDLC command words.
module tb_rs422_link_sched;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 16;
    localparam int unsigned TMO   = 100;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [31:0]   cmd_word = '0;
    logic          cmd_ready;
    logic          chk_req = 1'b0;
    logic          chk_done = 1'b0;
    logic          hdlc_tx_done = 1'b0;
    logic          hdlc_rx_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          chk_start;
    logic          hdlc_start;
    logic [31:0]   hdlc_cmd;
    logic          eng_abort;
    logic [1:0]    mode;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic [15:0]   frame_cnt;
    logic          err_ovf;
    logic          err_tmo;

    always #5 clk = ~clk;

    rs422_link_sched #(
        .FIFO_DEPTH  (DEPTH),
        .INTER_GAP   (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_word     (cmd_word),
        .cmd_ready    (cmd_ready),
        .chk_req      (chk_req),
        .chk_done     (chk_done),
        .hdlc_tx_done (hdlc_tx_done),
        .hdlc_rx_done (hdlc_rx_done),
        .err_clr      (err_clr),
        .chk_start    (chk_start),
        .hdlc_start   (hdlc_start),
        .hdlc_cmd     (hdlc_cmd),
        .eng_abort    (eng_abort),
        .mode         (mode),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .frame_cnt    (frame_cnt),
        .err_ovf      (err_ovf),
        .err_tmo      (err_tmo)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    logic [15:0] exp_frames = '0;
    logic [63:0] out_vec;

    // Scoreboard: every hdlc_start must carry the oldest accepted command word.
    always @(negedge clk) begin
        if (rstn && hdlc_start) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_start: hdlc_cmd=%h, no word was expected", hdlc_cmd);
            end else begin
                exp_word = exp_q.pop_front();
                if (hdlc_cmd !== exp_word) begin
                    n_bad++;
                    $display("FAIL sb_cmd_order: hdlc_cmd=%h required %h", hdlc_cmd, exp_word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit to_sb);
        cmd_word  = w;
        cmd_valid = 1'b1;
        if (to_sb) exp_q.push_back(w);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (hdlc_start !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        n_cmp++;
        if (hdlc_start !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start_timeout: hdlc_start=%b after %0d cycles, required 1",
                     tag, hdlc_start, n);
            n = -1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic finish_frame();
        hdlc_tx_done = 1'b1;
        hdlc_rx_done = 1'b1;
        tick();
        hdlc_tx_done = 1'b0;
        hdlc_rx_done = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        out_vec = {cmd_ready, chk_start, hdlc_start, hdlc_cmd, eng_abort, mode, busy,
                   fifo_level, frame_cnt, err_ovf, err_tmo};
        n_cmp++;
        if (out_vec !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: packed outputs=%h required 0", out_vec);
        end
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || mode !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b busy=%b mode=%0d required 1/0/0",
                     cmd_ready, busy, mode);
        end
    endtask

    task automatic test_single();
        push_word(32'hA5A5_0001, 1'b1);
        n_cmp++;
        if (fifo_level !== LW'(1) || hdlc_start !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_push: level=%0d start=%b required 1/0", fifo_level, hdlc_start);
        end
        tick();
        n_cmp++;
        if (mode !== 2'd2 || hdlc_start !== 1'b0 || fifo_level !== LW'(0)) begin
            n_bad++;
            $display("FAIL t1_load: mode=%0d start=%b level=%0d required 2/0/0",
                     mode, hdlc_start, fifo_level);
        end
        tick();
        n_cmp++;
        if (hdlc_start !== 1'b1 || hdlc_cmd !== 32'hA5A5_0001 || mode !== 2'd2) begin
            n_bad++;
            $display("FAIL t1_start: start=%b cmd=%h mode=%0d required 1/a5a50001/2",
                     hdlc_start, hdlc_cmd, mode);
        end
        repeat (9) tick();
        hdlc_tx_done = 1'b1;
        tick();
        hdlc_tx_done = 1'b0;
        n_cmp++;
        if (frame_cnt !== 16'd0 || mode !== 2'd2 || hdlc_start !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_tx_only: frame_cnt=%0d mode=%0d start=%b required 0/2/0",
                     frame_cnt, mode, hdlc_start);
        end
        repeat (9) tick();
        hdlc_rx_done = 1'b1;
        tick();
        hdlc_rx_done = 1'b0;
        exp_frames++;
        n_cmp++;
        if (frame_cnt !== exp_frames || mode !== 2'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_done: frame_cnt=%0d mode=%0d busy=%b required %0d/0/1",
                     frame_cnt, mode, busy, exp_frames);
        end
        repeat (GAP - 1) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_gap_hold: busy=%b required 1", busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || eng_abort !== 1'b0 || err_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_gap_end: busy=%b abort=%b tmo=%b required 0/0/0",
                     busy, eng_abort, err_tmo);
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [31:0] words [5];
        for (int i = 0; i < 5; i++) words[i] = 32'h0BAD_0000 + 32'(i);
        push_word(words[0], 1'b1);
        wait_start("t2_first", n);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL t2_ready_%0d: cmd_ready=%b required 1", i, cmd_ready);
            end
            push_word(words[i], 1'b1);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0 || fifo_level !== LW'(4) || err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_full: ready=%b level=%0d ovf=%b required 0/4/0",
                     cmd_ready, fifo_level, err_ovf);
        end
        push_word(32'hDEAD_0005, 1'b0);
        n_cmp++;
        if (err_ovf !== 1'b1 || fifo_level !== LW'(4)) begin
            n_bad++;
            $display("FAIL t2_drop: ovf=%b level=%0d required 1/4", err_ovf, fifo_level);
        end
        err_clr = 1'b1;
        push_word(32'hDEAD_0006, 1'b0);
        err_clr = 1'b0;
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_clr_priority: ovf=%b required 0", err_ovf);
        end
        push_word(32'hDEAD_0007, 1'b0);
        n_cmp++;
        if (err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL t2_reset_flag: ovf=%b required 1", err_ovf);
        end
        for (int k = 0; k < 5; k++) begin
            finish_frame();
            exp_frames++;
            if (k < 4) wait_start("t2_drain", n);
        end
        wait_idle("t2");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (err_ovf !== 1'b0 || frame_cnt !== exp_frames || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL t2_end: ovf=%b frame_cnt=%0d pending=%0d required 0/%0d/0",
                     err_ovf, frame_cnt, exp_q.size(), exp_frames);
        end
    endtask

    task automatic test_chk_priority();
        int n;
        chk_req   = 1'b1;
        cmd_word  = 32'hC0DE_0003;
        cmd_valid = 1'b1;
        exp_q.push_back(32'hC0DE_0003);
        tick();
        chk_req   = 1'b0;
        cmd_valid = 1'b0;
        n_cmp++;
        if (chk_start !== 1'b1 || hdlc_start !== 1'b0 || fifo_level !== LW'(1)) begin
            n_bad++;
            $display("FAIL t3_chk_first: chk_start=%b start=%b level=%0d required 1/0/1",
                     chk_start, hdlc_start, fifo_level);
        end
        tick();
        n_cmp++;
        if (mode !== 2'd1 || chk_start !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_chk_run: mode=%0d chk_start=%b required 1/0", mode, chk_start);
        end
        repeat (5) tick();
        n_cmp++;
        if (mode !== 2'd1 || fifo_level !== LW'(1)) begin
            n_bad++;
            $display("FAIL t3_chk_wait: mode=%0d level=%0d required 1/1", mode, fifo_level);
        end
        chk_done = 1'b1;
        tick();
        chk_done = 1'b0;
        n_cmp++;
        if (mode !== 2'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t3_chk_done: mode=%0d busy=%b required 0/1", mode, busy);
        end
        wait_start("t3", n);
        n_cmp++;
        if (n != int'(GAP) + 2) begin
            n_bad++;
            $display("FAIL t3_start_delay: cycles=%0d required %0d", n, GAP + 2);
        end
        finish_frame();
        exp_frames++;
        wait_idle("t3");
    endtask

    task automatic test_done_order();
        int n;
        for (int c = 0; c < 3; c++) begin
            push_word(32'h4D00_0000 + 32'(c), 1'b1);
            wait_start("t4", n);
            if (c == 0) begin
                finish_frame();
            end else begin
                hdlc_tx_done = (c == 1);
                hdlc_rx_done = (c == 2);
                tick();
                hdlc_tx_done = 1'b0;
                hdlc_rx_done = 1'b0;
                repeat (3) tick();
                n_cmp++;
                if (frame_cnt !== exp_frames || mode !== 2'd2) begin
                    n_bad++;
                    $display("FAIL t4_half_%0d: frame_cnt=%0d mode=%0d required %0d/2",
                             c, frame_cnt, mode, exp_frames);
                end
                hdlc_tx_done = (c == 2);
                hdlc_rx_done = (c == 1);
                tick();
                hdlc_tx_done = 1'b0;
                hdlc_rx_done = 1'b0;
            end
            exp_frames++;
            n_cmp++;
            if (frame_cnt !== exp_frames || mode !== 2'd0) begin
                n_bad++;
                $display("FAIL t4_frame_%0d: frame_cnt=%0d mode=%0d required %0d/0",
                         c, frame_cnt, mode, exp_frames);
            end
            // Stray strobes during the gap must not count.
            finish_frame();
            repeat (2) tick();
            n_cmp++;
            if (frame_cnt !== exp_frames) begin
                n_bad++;
                $display("FAIL t4_stray_%0d: frame_cnt=%0d required %0d", c, frame_cnt, exp_frames);
            end
            wait_idle("t4");
        end
    endtask

`ifdef RS422_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int early = 0;
        push_word(32'h7100_0000, 1'b1);
        wait_start("t5", n);
        for (int i = 2; i < int'(TMO); i++) begin
            tick();
            if (eng_abort !== 1'b0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL t5_early_abort: early pulses=%0d required 0", early);
        end
        tick();
        n_cmp++;
        if (eng_abort !== 1'b1 || mode !== 2'd2) begin
            n_bad++;
            $display("FAIL t5_abort: abort=%b mode=%0d required 1/2", eng_abort, mode);
        end
        tick();
        n_cmp++;
        if (eng_abort !== 1'b0 || err_tmo !== 1'b1 || frame_cnt !== exp_frames || mode !== 2'd0)
        begin
            n_bad++;
            $display("FAIL t5_after: abort=%b tmo=%b frame_cnt=%0d mode=%0d required 0/1/%0d/0",
                     eng_abort, err_tmo, frame_cnt, mode, exp_frames);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (err_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_clear: tmo=%b required 0", err_tmo);
        end
        wait_idle("t5");
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        push_word(32'h6600_0000, 1'b1);
        wait_start("t6", n);
        push_word(32'h6600_0001, 1'b0);
        push_word(32'h6600_0002, 1'b0);
        n_cmp++;
        if (fifo_level !== LW'(2) || mode !== 2'd2) begin
            n_bad++;
            $display("FAIL t6_queued: level=%0d mode=%0d required 2/2", fifo_level, mode);
        end
        #3;
        rstn = 1'b0;
        #1;
        out_vec = {cmd_ready, chk_start, hdlc_start, hdlc_cmd, eng_abort, mode, busy,
                   fifo_level, frame_cnt, err_ovf, err_tmo};
        n_cmp++;
        if (out_vec !== 64'd0) begin
            n_bad++;
            $display("FAIL t6_async_reset: packed outputs=%h required 0", out_vec);
        end
        exp_q.delete();
        exp_frames = '0;
        tick();
        rstn = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (busy !== 1'b0 || fifo_level !== LW'(0) || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL t6_after_release: busy=%b level=%0d frame_cnt=%0d required 0/0/0",
                     busy, fifo_level, frame_cnt);
        end
        push_word(32'h6600_0003, 1'b1);
        wait_start("t6_new", n);
        finish_frame();
        exp_frames++;
        n_cmp++;
        if (frame_cnt !== exp_frames) begin
            n_bad++;
            $display("FAIL t6_frame: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
        end
        wait_idle("t6");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_chk_priority();
        test_done_order();
`ifdef RS422_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d words never started, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
